// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, letter table and symbol-length helper.
// Code bit 0 is the first symbol played; a 1 bit is a dash.
package morse_pkg;

    typedef enum logic [1:0] {IDLE, ON, GAP, LGAP} state_t;

    localparam int MORSE_MAX_LEN     = 4;
    localparam int MORSE_NUM_LETTERS = 26;

    localparam logic [3:0] MORSE_CODE [MORSE_NUM_LETTERS] = '{
        4'b0010, 4'b0001, 4'b0101, 4'b0001, 4'b0000, 4'b0100, 4'b0011, 4'b0000,  // A-H
        4'b0000, 4'b1110, 4'b0101, 4'b0010, 4'b0011, 4'b0001, 4'b0111, 4'b0110,  // I-P
        4'b1011, 4'b0010, 4'b0000, 4'b0001, 4'b0100, 4'b1000, 4'b0110, 4'b1001,  // Q-X
        4'b1101, 4'b0011                                                          // Y-Z
    };

    localparam logic [2:0] MORSE_LEN [MORSE_NUM_LETTERS] = '{
        3'd2, 3'd4, 3'd4, 3'd3, 3'd1, 3'd4, 3'd3, 3'd4,
        3'd2, 3'd4, 3'd3, 3'd4, 3'd2, 3'd2, 3'd3, 3'd4,
        3'd4, 3'd3, 3'd3, 3'd1, 3'd3, 3'd4, 3'd3, 3'd4,
        3'd4, 3'd4
    };

    function automatic logic [1:0] unit_mult(input logic is_dash);
        return is_dash ? 2'd3 : 2'd1;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Loadable down-counter measuring 1 or 3 Morse units; pulses expire on the
// last cycle of the loaded interval and then idles until reloaded.
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [1:0] mult,
    output logic       expire
);

    localparam int CNT_W = $clog2(3 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] ONE_UNIT    = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] THREE_UNITS = CNT_W'(3 * UNIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             active;

    // Holds at zero once spent, so the count never wraps and expire fires once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= (mult == 2'd3) ? THREE_UNITS : ONE_UNIT;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign expire = active && (cnt == '0);

endmodule

// File: rtl/morse_letter_tx.sv
// Morse letter transmitter: a start pulse looks up a letter pattern and plays
// it on led_o with dot/dash/gap unit timing, reporting busy/done/err status.
module morse_letter_tx
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 25_000_000,
    parameter int SEL_W       = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [SEL_W-1:0] sel_i,
    input  logic             start_i,
    output logic             led_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [3:0]       code_o,
    output logic [2:0]       len_o
);

    state_t     state, state_n;
    logic [3:0] shreg, shreg_n;
    logic [2:0] sym_left, sym_left_n;
    logic [3:0] code_n;
    logic [2:0] len_n;
    logic       led_n, busy_n, done_n, err_n;
    logic       tmr_load, tmr_expire;
    logic [1:0] tmr_mult;
    logic [4:0] sel_ext;
    logic       sel_valid;

    assign sel_ext   = 5'(sel_i);
    assign sel_valid = sel_ext < 5'(MORSE_NUM_LETTERS);

    morse_unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_timer (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .load  (tmr_load),
        .mult  (tmr_mult),
        .expire(tmr_expire)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            shreg    <= '0;
            sym_left <= '0;
            code_o   <= '0;
            len_o    <= '0;
            led_o    <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            sym_left <= sym_left_n;
            code_o   <= code_n;
            len_o    <= len_n;
            led_o    <= led_n;
            busy_o   <= busy_n;
            done_o   <= done_n;
            err_o    <= err_n;
        end
    end

    // Every transition into a timed state reloads the unit timer.
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        sym_left_n = sym_left;
        code_n     = code_o;
        len_n      = len_o;
        done_n     = 1'b0;
        err_n      = 1'b0;
        tmr_load   = 1'b0;
        tmr_mult   = 2'd1;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    if (sel_valid) begin
                        code_n     = MORSE_CODE[sel_ext];
                        len_n      = MORSE_LEN[sel_ext];
                        shreg_n    = code_n;
                        sym_left_n = len_n;
                        tmr_load   = 1'b1;
                        tmr_mult   = unit_mult(code_n[0]);
                        state_n    = ON;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ON: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    if (sym_left > 3'd1) begin
                        state_n = GAP;
                    end else begin
                        tmr_mult = 2'd3;
                        state_n  = LGAP;
                    end
                end
            end
            GAP: begin
                if (tmr_expire) begin
                    shreg_n    = shreg >> 1;
                    sym_left_n = sym_left - 3'd1;
                    tmr_load   = 1'b1;
                    tmr_mult   = unit_mult(shreg[1]);
                    state_n    = ON;
                end
            end
            LGAP: begin
                if (tmr_expire) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        led_n  = (state_n == ON);
        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_morse_letter_tx.sv
// Directed bench for morse_letter_tx: hand-computed LED waveforms per letter,
// plus busy-ignore, invalid index, async reset and back-to-back sequences.
module tb_morse_letter_tx;

    typedef struct {
        logic [4:0]  sel;
        logic [3:0]  code;
        logic [2:0]  len;
        int          n;
        logic [31:0] wave;   // bit n-1 is the first cycle after the start edge
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] sel;
    logic       start;
    int         which;
    int         checks   = 0;
    int         failures = 0;

    logic       start_a, start_b, start_c;
    logic       led_a, busy_a, done_a, err_a;
    logic       led_b, busy_b, done_b, err_b;
    logic       led_c, busy_c, done_c, err_c;
    logic [3:0] code_a, code_b, code_c;
    logic [2:0] len_a, len_b, len_c;
    logic       m_led, m_busy, m_done, m_err;
    logic [3:0] m_code;
    logic [2:0] m_len;

    vec_t vecs[8];

    always #5 clk = ~clk;

    assign start_a = start && (which == 0);
    assign start_b = start && (which == 1);
    assign start_c = start && (which == 2);

    morse_letter_tx #(.UNIT_CYCLES(2), .SEL_W(3)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .sel_i(sel[2:0]), .start_i(start_a),
        .led_o(led_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a),
        .code_o(code_a), .len_o(len_a)
    );

    morse_letter_tx #(.UNIT_CYCLES(2), .SEL_W(5)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .sel_i(sel), .start_i(start_b),
        .led_o(led_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b),
        .code_o(code_b), .len_o(len_b)
    );

    morse_letter_tx #(.UNIT_CYCLES(1), .SEL_W(3)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .sel_i(sel[2:0]), .start_i(start_c),
        .led_o(led_c), .busy_o(busy_c), .done_o(done_c), .err_o(err_c),
        .code_o(code_c), .len_o(len_c)
    );

    always_comb begin
        m_led = led_a; m_busy = busy_a; m_done = done_a; m_err = err_a;
        m_code = code_a; m_len = len_a;
        if (which == 1) begin
            m_led = led_b; m_busy = busy_b; m_done = done_b; m_err = err_b;
            m_code = code_b; m_len = len_b;
        end else if (which == 2) begin
            m_led = led_c; m_busy = busy_c; m_done = done_c; m_err = err_c;
            m_code = code_c; m_len = len_c;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (dut %0d, t=%0t): got %0h expected %0h", name, which, $time, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first output cycle.
    task automatic pulse_start(input logic [4:0] s);
        sel   = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Checks n output cycles, optionally injecting a start at cycle inj_at,
    // and returns at the done cycle after checking it.
    task automatic check_wave(input int n, input logic [31:0] wave,
                              input int inj_at, input logic [4:0] inj_sel);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("led[%0d]", i), 32'(m_led), 32'(wave[n-1-i]));
            chk($sformatf("busy[%0d]", i), 32'(m_busy), 32'd1);
            chk($sformatf("err[%0d]", i), 32'(m_err), 32'd0);
            if (i == inj_at) begin
                sel   = inj_sel;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_end", 32'(m_busy), 32'd0);
        chk("done_end", 32'(m_done), 32'd1);
        chk("led_end", 32'(m_led), 32'd0);
    endtask

    initial begin
        vecs[0] = '{5'd0, 4'b0010, 3'd2, 16, 32'b1100111111000000};
        vecs[1] = '{5'd1, 4'b0001, 3'd4, 24, 32'b111111001100110011000000};
        vecs[2] = '{5'd2, 4'b0101, 3'd4, 28, 32'b1111110011001111110011000000};
        vecs[3] = '{5'd3, 4'b0001, 3'd3, 20, 32'b11111100110011000000};
        vecs[4] = '{5'd4, 4'b0000, 3'd1, 8,  32'b11000000};
        vecs[5] = '{5'd5, 4'b0100, 3'd4, 24, 32'b110011001111110011000000};
        vecs[6] = '{5'd6, 4'b0011, 3'd3, 24, 32'b111111001111110011000000};
        vecs[7] = '{5'd7, 4'b0000, 3'd4, 20, 32'b11001100110011000000};

        which = 0;
        sel   = '0;
        start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            which = w;
            #1;
            chk("rst_led", 32'(m_led), 32'd0);
            chk("rst_busy", 32'(m_busy), 32'd0);
            chk("rst_done", 32'(m_done), 32'd0);
            chk("rst_err", 32'(m_err), 32'd0);
            chk("rst_code", 32'(m_code), 32'd0);
            chk("rst_len", 32'(m_len), 32'd0);
        end
        which = 0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            pulse_start(vecs[v].sel);
            check_wave(vecs[v].n, vecs[v].wave, -1, 5'd0);
            chk("code", 32'(m_code), 32'(vecs[v].code));
            chk("len", 32'(m_len), 32'(vecs[v].len));
            @(negedge clk);
            chk("done_pulse", 32'(m_done), 32'd0);
        end

        // 'B' with an extra start (sel 7) at cycle 5 that must be ignored
        pulse_start(5'd1);
        check_wave(24, 32'b111111001100110011000000, 5, 5'd7);
        chk("ign_code", 32'(m_code), 32'b0001);
        chk("ign_len", 32'(m_len), 32'd4);
        @(negedge clk);

        // reset during the second symbol of 'D', then a clean 'H'
        pulse_start(5'd3);
        repeat (8) @(negedge clk);
        chk("mid_led", 32'(m_led), 32'd1);
        chk("mid_busy", 32'(m_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_led", 32'(m_led), 32'd0);
        chk("arst_busy", 32'(m_busy), 32'd0);
        chk("arst_done", 32'(m_done), 32'd0);
        @(negedge clk);
        chk("arst_done2", 32'(m_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_done", 32'(m_done), 32'd0);
        chk("post_busy", 32'(m_busy), 32'd0);
        pulse_start(5'd7);
        check_wave(20, 32'b11001100110011000000, -1, 5'd0);
        chk("h_code", 32'(m_code), 32'b0000);
        chk("h_len", 32'(m_len), 32'd4);

        // back-to-back 'G' then 'A' started in the done cycle, unit = 2
        @(negedge clk);
        pulse_start(5'd6);
        check_wave(24, 32'b111111001111110011000000, -1, 5'd0);
        pulse_start(5'd0);
        check_wave(16, 32'b1100111111000000, -1, 5'd0);
        chk("b2b_code", 32'(m_code), 32'b0010);
        chk("b2b_len", 32'(m_len), 32'd2);

        // wide select: 'Z', then rejected indices 27 and 26
        which = 1;
        @(negedge clk);
        pulse_start(5'd25);
        check_wave(28, 32'b1111110011111100110011000000, -1, 5'd0);
        chk("z_code", 32'(m_code), 32'b0011);
        chk("z_len", 32'(m_len), 32'd4);
        @(negedge clk);
        pulse_start(5'd27);
        chk("err27", 32'(m_err), 32'd1);
        chk("err27_busy", 32'(m_busy), 32'd0);
        chk("err27_led", 32'(m_led), 32'd0);
        chk("err27_code", 32'(m_code), 32'b0011);
        chk("err27_len", 32'(m_len), 32'd4);
        @(negedge clk);
        chk("err27_pulse", 32'(m_err), 32'd0);
        chk("err27_busy2", 32'(m_busy), 32'd0);
        pulse_start(5'd26);
        chk("err26", 32'(m_err), 32'd1);
        @(negedge clk);
        chk("err26_pulse", 32'(m_err), 32'd0);
        chk("err26_code", 32'(m_code), 32'b0011);

        // back-to-back 'G' then 'A' at minimum unit length
        which = 2;
        @(negedge clk);
        pulse_start(5'd6);
        check_wave(12, 32'b111011101000, -1, 5'd0);
        pulse_start(5'd0);
        check_wave(8, 32'b10111000, -1, 5'd0);
        chk("u1_code", 32'(m_code), 32'b0010);
        @(negedge clk);
        chk("u1_done_pulse", 32'(m_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete by t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/morse_letter_tx.md
# morse_letter_tx

Parametrised Morse letter transmitter: the successor to the switch-driven letter decoder. A start pulse samples a letter index, looks up its dot/dash pattern and length in a shared table, and plays it on a single LED output with standard Morse unit timing, tracking busy/done status. It sits between the debounced key/switch inputs and the board LED, and replaces the decoder plus external timing logic.

## Interface
- UNIT_CYCLES, 25_000_000: clock cycles per Morse time unit (0.5 s at 50 MHz); legal range ≥ 1.
- SEL_W, 3: letter-select width; index 0 = 'A'. Legal range 1..5. With 3, A..H is selectable; with 5, A..Z.
- clk_i  input  1  system clock, all state on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- sel_i  input  SEL_W  letter index, sampled only on an accepted start.
- start_i  input  1  one-cycle request pulse, already synchronised and debounced upstream.
- led_o  output  1  Morse output: 1 = tone/LED on.
- busy_o  output  1  high while a letter (including its trailing gap) is in progress.
- done_o  output  1  one-cycle pulse when a letter completes.
- err_o  output  1  one-cycle pulse when start is rejected for an index ≥ 26.
- code_o  output  4  latched pattern of the current/last letter (bit 0 = first symbol, 1 = dash, unused bits 0).
- len_o  output  3  latched symbol count of the current/last letter (1..4).

## Operation
- Table encoding: A .- = code 0010, len 2; B -... = 0001/4; C -.-. = 0101/4; D -.. = 001/3; E . = 0/1; F ..-. = 0100/4; G --. = 011/3; H .... = 0000/4; I..Z follow the same rule.
- Symbol durations: dot = 1 unit on; dash = 3 units on; inter-symbol gap = 1 unit off; trailing letter gap = 3 units off.
- FSM states: IDLE, ON, GAP, LGAP.
  - IDLE: led 0, busy 0. On start_i with valid index, latch code/len into a shift register and symbol counter, go to ON. With invalid index: pulse err_o, stay IDLE, code_o/len_o unchanged.
  - ON: led 1 for 1 or 3 units according to the current symbol bit. At expiry: if symbols remain, go to GAP; otherwise, go to LGAP.
  - GAP: led 0 for 1 unit, shift to the next symbol, go to ON.
  - LGAP: led 0 for 3 units, then go to IDLE with done_o = 1 for that first IDLE cycle.
- start_i while busy_o = 1 is ignored: no err, no restart, sel_i not sampled.
- Unit timer counter width is $clog2(3*UNIT_CYCLES). It reloads on every state entry and never wraps.

## Timing
- Reset (async assert): state IDLE; led_o, busy_o, done_o, err_o = 0; code_o = 0, len_o = 0. Counters cleared. Reset mid-letter aborts immediately with no done_o.
- Start accepted on edge 0 → led_o = 1 and busy_o = 1 from the cycle after edge 0 (1-cycle latency).
- Each unit lasts exactly UNIT_CYCLES cycles. Total busy cycles = UNIT_CYCLES × (sum of on-units + (len−1) + 3).
- done_o is asserted in the first cycle with busy_o = 0. A start_i in that same cycle is accepted, which allows back-to-back letters.
- err_o is asserted in the cycle after the rejected start edge.
- All outputs are registered.

## Structure
- Package morse_pkg:
  - state_t enum.
  - MORSE_MAX_LEN = 4 and MORSE_NUM_LETTERS = 26.
  - Constant arrays MORSE_CODE[26] (4-bit) and MORSE_LEN[26] (3-bit).
- Sub-module morse_unit_timer:
  - Loadable down-counter taking a unit multiple (1 or 3) and UNIT_CYCLES.
  - Produces a one-cycle expire pulse.
- The top level holds the FSM, shift register, symbol counter and output registers.

## Test plan
All scenarios use UNIT_CYCLES = 2 unless stated.
- Reset then sel_i = 0 ('A'), start: led_o = 1 for 2 cycles, 0 for 2, 1 for 6, 0 for 6. busy_o is high for 16 cycles, then done_o pulses. code_o = 0010, len_o = 2.
- sel_i = 4 ('E'): led_o is high for 2 cycles, then low for 6. busy_o is high for 8 cycles, then done_o pulses.
- 'B' playing; pulse start_i with sel_i = 7 at cycle 5: the waveform is unchanged, code_o stays 0001, err_o = 0.
- SEL_W = 5, sel_i = 27, start: err_o pulses once, busy_o stays 0, code_o/len_o keep their prior values.
- Start 'D', assert rst_ni low during the second symbol: led_o/busy_o go to 0 asynchronously, with no done_o. After release, start 'H': the full 4-dot sequence plays.
- Start 'G', then start 'A' in the done_o cycle: the second letter begins on the next cycle with no extra idle gap. Repeat with UNIT_CYCLES = 1 for the minimum-timing check.
